serial_tx_arbiter: RTL and testbench

//  Shares one serial_tx byte transmitter between NUM_REQ byte sources (debug, status, command replies).

---
 rtl/serial_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//   Shares one serial_tx byte transmitter between NUM_REQ byte sources. Sources offer bytes
//   with a valid/ready handshake and are served round-robin; the winning byte is handed to
//   serial_tx with a one-cycle new_data pulse and the arbiter then follows tx_busy until the
//   frame completes. All outputs are registered.
//
//   Optional build macro: SERIAL_TX_ARB_LOCK_EN adds req_last and keeps the grant on one
//   source until that source's byte marked last has been issued (or a drop occurs).
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   req_valid    per-source byte valid, held with req_data until req_ready
//   req_data     byte of source i at [8*i+7:8*i]
//   req_last     (SERIAL_TX_ARB_LOCK_EN only) per-source end-of-message flag
//   req_ready    one-hot, one-cycle handshake pulse
//   pause        1 = no new grants; the byte in flight completes
//   tx_data      byte to serial_tx
//   tx_new_data  one-cycle start pulse to serial_tx
//   tx_busy      busy flag from serial_tx
//   grant_id     index of the last granted source
//   drop_err     one-cycle pulse when serial_tx never started an issued byte
module serial_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 3,
  localparam int unsigned REQ_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
`ifdef SERIAL_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_last,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 pause,
  output logic [7:0]           tx_data,
  output logic                 tx_new_data,
  input  logic                 tx_busy,
  output logic [REQ_W-1:0]     grant_id,
  output logic                 drop_err
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ISSUE      = 2'd1;
  localparam logic [1:0] WAIT_START = 2'd2;
  localparam logic [1:0] WAIT_DONE  = 2'd3;

  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [7:0]         data_q, data_d;
  logic               new_q, new_d;
  logic [REQ_W-1:0]   grant_q, grant_d;
  logic               drop_q, drop_d;
  logic [REQ_W-1:0]   rr_q, rr_d;
`ifdef SERIAL_TX_ARB_LOCK_EN
  logic               lock_q, lock_d;
  logic [REQ_W-1:0]   lock_id_q, lock_id_d;
`endif

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [REQ_W-1:0]   winner;
  logic               grant_ok;

  // Round-robin search starting just after the last winner.
  always_comb begin
    logic [REQ_W:0]   sum;
    logic [REQ_W-1:0] cand;
    elig = req_valid;
`ifdef SERIAL_TX_ARB_LOCK_EN
    if (lock_q) elig = req_valid & (NUM_REQ'(1) << lock_id_q);
`endif
    found  = 1'b0;
    winner = rr_q;
    sum    = '0;
    cand   = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      sum = {1'b0, rr_q} + (REQ_W + 1)'(i);
      if (sum >= (REQ_W + 1)'(NUM_REQ)) sum = sum - (REQ_W + 1)'(NUM_REQ);
      cand = sum[REQ_W-1:0];
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // WAIT_DONE with busy low behaves as IDLE so back-to-back bytes lose no cycle.
  assign grant_ok = !pause && !tx_busy && found &&
                    ((state_q == IDLE) || (state_q == WAIT_DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = '0;
    new_d   = 1'b0;
    drop_d  = 1'b0;
    data_d  = data_q;
    grant_d = grant_q;
    rr_d    = rr_q;
`ifdef SERIAL_TX_ARB_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
`endif
    case (state_q)
      IDLE: ;
      ISSUE: begin
        state_d = WAIT_START;
        cnt_d   = '0;
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          // Byte was already handshaken with its source, so it is lost, not retried.
          drop_d  = 1'b1;
          state_d = IDLE;
`ifdef SERIAL_TX_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant_ok) begin
      state_d         = ISSUE;
      data_d          = req_data[{winner, 3'b000} +: 8];
      grant_d         = winner;
      rr_d            = winner;
      ready_d[winner] = 1'b1;
      new_d           = 1'b1;
`ifdef SERIAL_TX_ARB_LOCK_EN
      lock_d          = ~req_last[winner];
      lock_id_d       = winner;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ready_q   <= '0;
      data_q    <= '0;
      new_q     <= 1'b0;
      grant_q   <= '0;
      drop_q    <= 1'b0;
      rr_q      <= REQ_W'(NUM_REQ - 1);
`ifdef SERIAL_TX_ARB_LOCK_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      new_q     <= new_d;
      grant_q   <= grant_d;
      drop_q    <= drop_d;
      rr_q      <= rr_d;
`ifdef SERIAL_TX_ARB_LOCK_EN
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`endif
    end
  end

  assign req_ready   = ready_q;
  assign tx_data     = data_q;
  assign tx_new_data = new_q;
  assign grant_id    = grant_q;
  assign drop_err    = drop_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: four byte sources, a serial_tx busy model (busy rises one
// cycle after new_data and lasts 40 cycles), and a scoreboard of expected issues/drops.
module tb_serial_tx_arbiter;

  localparam int DROP_LAT = 4;  // ISSUE cycle plus three WAIT_START cycles

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        pause;
  logic [7:0]  tx_data;
  logic        tx_new_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        drop_err;

  always #5 clk = ~clk;

  serial_tx_arbiter #(
    .NUM_REQ       (4),
    .START_TIMEOUT (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef SERIAL_TX_ARB_LOCK_EN
    .req_last    (req_last),
`endif
    .req_ready   (req_ready),
    .pause       (pause),
    .tx_data     (tx_data),
    .tx_new_data (tx_new_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .drop_err    (drop_err)
  );

  typedef struct {
    bit         is_drop;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nd_cnt = 0, nd_cyc = 0, drop_cnt = 0, drop_cyc = 0, rdy_cnt = 0;
  bit   ignore_nd;

  logic [7:0] src_mem  [4][16];
  logic       src_lmem [4][16];
  logic [3:0] wr_ptr   [4];
  logic [3:0] rd_ptr   [4];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.is_drop = 1'b0;
    e.id      = id;
    e.data    = d;
    sb.push_back(e);
  endtask

  task automatic expect_drop();
    exp_t e;
    e.is_drop = 1'b1;
    e.id      = '0;
    e.data    = '0;
    sb.push_back(e);
  endtask

  task automatic load(input logic [1:0] s, input logic [7:0] d, input logic last);
    src_mem[s][wr_ptr[s]]  = d;
    src_lmem[s][wr_ptr[s]] = last;
    wr_ptr[s]              = wr_ptr[s] + 4'd1;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    for (int k = 0; k < 3000 && quiet < 8; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !tx_busy && !tx_new_data && req_valid == 4'b0000) quiet++;
      else quiet = 0;
    end
    check_eq(name, quiet, 8);
  endtask

  // Sources: present the head byte; advance after a valid&ready cycle.
  initial begin
    logic [3:0] hs;
    for (int i = 0; i < 4; i++) rd_ptr[i] = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) rd_ptr[i] = rd_ptr[i] + 4'd1;
        req_valid[i]      = (rd_ptr[i] != wr_ptr[i]);
        req_data[8*i +: 8] = src_mem[i][rd_ptr[i]];
        req_last[i]       = src_lmem[i][rd_ptr[i]];
      end
    end
  end

  // serial_tx busy model.
  initial begin
    int  busy_cnt = 0;
    bit  start;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      start = tx_new_data && !ignore_nd && rst;
      @(posedge clk);
      #1;
      if (!rst) busy_cnt = 0;
      else if (busy_cnt != 0) busy_cnt--;
      else if (start) busy_cnt = 40;
      tx_busy = (busy_cnt != 0);
    end
  end

  // Monitor: pops the scoreboard on every issue or drop.
  initial begin
    exp_t       e;
    logic [3:0] exp_rdy;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (req_ready != 4'b0000) rdy_cnt++;
        if (drop_err) begin
          drop_cnt++;
          drop_cyc = cyc;
          check_eq("drop_latency", cyc - nd_cyc, DROP_LAT);
          if (sb.size() == 0) check_eq("unexpected_drop", 1, 0);
          else begin
            e = sb.pop_front();
            check_eq("drop_expected", {31'd0, e.is_drop}, 1);
          end
        end
        if (tx_new_data) begin
          nd_cnt++;
          nd_cyc = cyc;
          check_eq("new_data_while_busy", {31'd0, tx_busy}, 0);
          if (sb.size() == 0) check_eq("unexpected_new_data", 1, 0);
          else begin
            e       = sb.pop_front();
            exp_rdy = 4'b0001 << e.id;
            check_eq("issue_not_drop", {31'd0, e.is_drop}, 0);
            check_eq("tx_data", tx_data, e.data);
            check_eq("grant_id", grant_id, e.id);
            check_eq("req_ready", req_ready, exp_rdy);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int nd0, rdy0, drop0, dcyc;
    for (int i = 0; i < 4; i++) wr_ptr[i] = '0;
    rst = 1'b0; pause = 1'b0; ignore_nd = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_new_data", {31'd0, tx_new_data}, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_drop_err", {31'd0, drop_err}, 0);
    rst = 1'b1;

    // 1) single source, one-cycle latency
    expect_byte(2'd0, 8'hA5);
    load(2'd0, 8'hA5, 1'b1);
    for (int k = 0; k < 20 && !req_valid[0]; k++) @(negedge clk);
    @(negedge clk);
    check_eq("t1_latency", {31'd0, tx_new_data}, 1);
    wait_idle("t1_done");

    // 2) all sources valid after reset: order 0,1,2,3,0
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_byte(2'd0, 8'h10);
    expect_byte(2'd1, 8'h11);
    expect_byte(2'd2, 8'h12);
    expect_byte(2'd3, 8'h13);
    expect_byte(2'd0, 8'h14);
    load(2'd0, 8'h10, 1'b1);
    load(2'd0, 8'h14, 1'b1);
    load(2'd1, 8'h11, 1'b1);
    load(2'd2, 8'h12, 1'b1);
    load(2'd3, 8'h13, 1'b1);
    wait_idle("t2_done");

    // 3) pause blocks grants; grant one cycle after release
    pause = 1'b1;
    load(2'd2, 8'h5C, 1'b1);
    nd0 = nd_cnt; rdy0 = rdy_cnt;
    repeat (100) @(negedge clk);
    check_eq("t3_no_new_data", nd_cnt - nd0, 0);
    check_eq("t3_no_ready", rdy_cnt - rdy0, 0);
    expect_byte(2'd2, 8'h5C);
    pause = 1'b0;
    @(negedge clk);
    check_eq("t3_ready_after_pause", req_ready, 4'b0100);
    wait_idle("t3_done");

    // 4) serial_tx ignores new_data: drop, then next source granted from IDLE
    ignore_nd = 1'b1;
    nd0 = nd_cnt; drop0 = drop_cnt;
    expect_byte(2'd3, 8'h3D);
    expect_drop();
    expect_byte(2'd0, 8'h0A);
    expect_drop();
    load(2'd3, 8'h3D, 1'b1);
    load(2'd0, 8'h0A, 1'b1);
    for (int k = 0; k < 200 && drop_cnt < drop0 + 1; k++) @(negedge clk);
    check_eq("t4_drop_seen", drop_cnt - drop0, 1);
    dcyc = drop_cyc;
    for (int k = 0; k < 200 && nd_cnt < nd0 + 2; k++) @(negedge clk);
    check_eq("t4_regrant_after_drop", nd_cyc - dcyc, 1);
    wait_idle("t4_done");
    check_eq("t4_two_drops", drop_cnt - drop0, 2);
    ignore_nd = 1'b0;

    // 5) message lock vs. per-byte arbitration
`ifdef SERIAL_TX_ARB_LOCK_EN
    expect_byte(2'd1, 8'h01);
    expect_byte(2'd1, 8'h02);
    expect_byte(2'd1, 8'h03);
    expect_byte(2'd0, 8'hB0);
`else
    expect_byte(2'd1, 8'h01);
    expect_byte(2'd0, 8'hB0);
    expect_byte(2'd1, 8'h02);
    expect_byte(2'd1, 8'h03);
`endif
    load(2'd1, 8'h01, 1'b0);
    load(2'd1, 8'h02, 1'b0);
    load(2'd1, 8'h03, 1'b1);
    load(2'd0, 8'hB0, 1'b1);
    wait_idle("t5_done");

    // 6) reset during WAIT_DONE
    expect_byte(2'd2, 8'h66);
    nd0 = nd_cnt;
    load(2'd2, 8'h66, 1'b1);
    for (int k = 0; k < 50 && nd_cnt == nd0; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    check_eq("t6_busy_before_reset", {31'd0, tx_busy}, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_rst_tx_data", tx_data, 0);
    check_eq("t6_rst_grant_id", grant_id, 0);
    check_eq("t6_rst_req_ready", req_ready, 0);
    check_eq("t6_rst_tx_new_data", {31'd0, tx_new_data}, 0);
    check_eq("t6_rst_drop_err", {31'd0, drop_err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    expect_byte(2'd0, 8'h70);
    expect_byte(2'd3, 8'h73);
    load(2'd0, 8'h70, 1'b1);
    load(2'd3, 8'h73, 1'b1);
    wait_idle("t6_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
